// File: rtl/adc_scan_uart.sv
// Multi-channel ADC scan sequencer: steps the analog mux, handshakes one conversion
// per channel and ships each sample as an async serial frame. Optional parity: ADC_SCAN_UART_PARITY_EN.
module adc_scan_uart #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 104,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      eoc,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      dsr,
  output logic                      soc,
  output logic                      load_dato,
  output logic                      mux_en,
  output logic [$clog2(NUM_CH)-1:0] canale,
  output logic                      data_out,
  output logic                      tx_busy,
  output logic                      error
);
  localparam int CH_W = $clog2(NUM_CH);
`ifdef ADC_SCAN_UART_PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int NW = $clog2(NBITS);

  typedef enum logic [2:0] {S_MUX, S_SETTLE, S_SOC, S_WAIT, S_LOAD, S_REQ, S_TX} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [NW-1:0]     bit_q, bit_d;
  logic [NBITS-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CH_W-1:0]   canale_q, canale_d;
  logic soc_q, soc_d, load_q, load_d, mux_en_q, mux_en_d;
  logic data_out_q, data_out_d, tx_busy_q, tx_busy_d, error_q, error_d;
  logic [NBITS-1:0]  frame;

  // Transmit order is MSB first: start, data MSB..LSB, [parity], stop.
`ifdef ADC_SCAN_UART_PARITY_EN
  assign frame = {1'b0, hold_q, ^hold_q, 1'b1};
`else
  assign frame = {1'b0, hold_q, 1'b1};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_MUX;
      settle_q   <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      canale_q   <= '0;
      soc_q      <= 1'b0;
      load_q     <= 1'b0;
      mux_en_q   <= 1'b0;
      data_out_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      canale_q   <= canale_d;
      soc_q      <= soc_d;
      load_q     <= load_d;
      mux_en_q   <= mux_en_d;
      data_out_q <= data_out_d;
      tx_busy_q  <= tx_busy_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    canale_d   = canale_q;
    soc_d      = 1'b0;
    load_d     = 1'b0;
    mux_en_d   = mux_en_q;
    data_out_d = data_out_q;
    tx_busy_d  = tx_busy_q;
    error_d    = error_q;
    unique case (state_q)
      S_MUX: begin
        mux_en_d = 1'b1;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d = S_SOC;
        else settle_d = settle_q + SW'(1);
      end
      S_SOC: begin
        soc_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Capture on the eoc edge so hold is valid while load_dato is high.
        if (eoc) begin
          hold_d   = data_in;
          load_d   = 1'b1;
          mux_en_d = 1'b0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD, S_REQ: begin
        if (dsr) begin
          error_d    = 1'b0;
          tx_busy_d  = 1'b1;
          data_out_d = frame[NBITS-1];
          shift_d    = frame;
          baud_d     = '0;
          bit_d      = '0;
          state_d    = S_TX;
        end else begin
          error_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_TX: begin
        if (baud_q == BW'(BAUD_DIV - 1)) begin
          baud_d = '0;
          if (bit_q == NW'(NBITS - 1)) begin
            data_out_d = 1'b1;
            tx_busy_d  = 1'b0;
            canale_d   = (canale_q == CH_W'(NUM_CH - 1)) ? '0 : canale_q + CH_W'(1);
            state_d    = S_MUX;
          end else begin
            bit_d      = bit_q + NW'(1);
            data_out_d = shift_q[NBITS-2];
            shift_d    = shift_q << 1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_MUX;
    endcase
  end

  assign soc       = soc_q;
  assign load_dato = load_q;
  assign mux_en    = mux_en_q;
  assign canale    = canale_q;
  assign data_out  = data_out_q;
  assign tx_busy   = tx_busy_q;
  assign error     = error_q;
endmodule

// File: tb/tb_adc_scan_uart.sv
// Bench for adc_scan_uart: a randomised ADC/receiver responder checked against
// per-scan expectations derived from the frame format, settle delay and channel wrap.
module tb_adc_scan_uart;
  localparam int NUM_CH     = 5;
  localparam int DATA_W     = 8;
  localparam int BAUD_DIV   = 104;
  localparam int SETTLE_CYC = 2;
  localparam int CH_W       = $clog2(NUM_CH);
`ifdef ADC_SCAN_UART_PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              eoc = 1'b0;
  logic              dsr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              soc, load_dato, mux_en, data_out, tx_busy, error;
  logic [CH_W-1:0]   canale;

  int n_chk = 0;
  int n_err = 0;
  int exp_ch = 0;

  always #5 clock = ~clock;

  adc_scan_uart #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BAUD_DIV(BAUD_DIV), .SETTLE_CYC(SETTLE_CYC)
  ) u_dut (
    .clock(clock), .reset(reset), .eoc(eoc), .data_in(data_in), .dsr(dsr),
    .soc(soc), .load_dato(load_dato), .mux_en(mux_en), .canale(canale),
    .data_out(data_out), .tx_busy(tx_busy), .error(error)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // k-th transmitted bit of the frame carrying v.
  function automatic logic exp_bit(input logic [DATA_W-1:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k <= DATA_W) return v[DATA_W-k];
`ifdef ADC_SCAN_UART_PARITY_EN
    if (k == DATA_W + 1) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic run_scan(input logic [DATA_W-1:0] val, input int eoc_dly, input bit early,
                          input int stall, input int abort_bit);
    int n, good, busy, bad, errh;
    n = 0;
    while (!mux_en && n < 20) begin step(); n++; end
    chk("mux_en_rise", int'(mux_en), 1);
    chk("canale", int'(canale), exp_ch);
    // Settle phase: eoc noise here must be ignored unless it is still high once WAIT is entered.
    n = 0;
    while (!soc && n < 20) begin
      eoc     = early ? 1'b1 : (($urandom % 4) == 0);
      data_in = early ? val : DATA_W'($urandom);
      dsr     = 1'($urandom);
      step();
      n++;
    end
    chk("soc_delay", n, SETTLE_CYC + 1);
    bad = 0;
    if (!early) begin
      eoc = 1'b0;
      for (int i = 0; i < eoc_dly; i++) begin
        step();
        if (soc || load_dato) bad++;
      end
    end
    chk("wait_quiet", bad, 0);
    eoc = 1'b1;
    data_in = val;
    step();
    chk("load_dato", int'(load_dato), 1);
    chk("load_mux_off", int'(mux_en), 0);
    chk("load_err_idle", int'(error), 0);
    eoc = 1'b0;
    data_in = DATA_W'($urandom);
    bad = 0;
    errh = 0;
    for (int i = 0; i < stall; i++) begin
      dsr = 1'b0;
      step();
      if (error) errh++;
      if (tx_busy || !data_out || load_dato) bad++;
    end
    chk("stall_line_idle", bad, 0);
    chk("error_cycles", errh, stall);
    dsr = 1'b1;
    step();
    chk("error_clr", int'(error), 0);
    busy = 0;
    for (int b = 0; b < NBITS; b++) begin
      good = 0;
      for (int c = 0; c < BAUD_DIV; c++) begin
        if (b == abort_bit && c == BAUD_DIV / 2) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          chk("rst_data_out", int'(data_out), 1);
          chk("rst_tx_busy", int'(tx_busy), 0);
          chk("rst_canale", int'(canale), 0);
          chk("rst_error", int'(error), 0);
          chk("rst_mux_en", int'(mux_en), 0);
          exp_ch = 0;
          step();
          chk("rst_rescan", int'(mux_en), 1);
          return;
        end
        if (data_out === exp_bit(val, b)) good++;
        if (tx_busy && !error) busy++;
        dsr = 1'($urandom);
        eoc = 1'($urandom);
        step();
      end
      chk($sformatf("bit%0d", b), good, BAUD_DIV);
    end
    eoc = 1'b0;
    chk("busy_len", busy, NBITS * BAUD_DIV);
    chk("post_tx_busy", int'(tx_busy), 0);
    chk("post_data_out", int'(data_out), 1);
    exp_ch = (exp_ch + 1) % NUM_CH;
    chk("post_canale", int'(canale), exp_ch);
    chk("post_mux_off", int'(mux_en), 0);
    step();
    chk("mux_next", int'(mux_en), 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step();
    chk("rst_soc", int'(soc), 0);
    chk("rst_load", int'(load_dato), 0);
    chk("rst_mux", int'(mux_en), 0);
    chk("rst_ch", int'(canale), 0);
    chk("rst_line", int'(data_out), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_err", int'(error), 0);
    reset = 1'b0;
    step();
    chk("mux_first", int'(mux_en), 1);
    run_scan(8'hA5, 5, 1'b0, 0, -1);
    run_scan(DATA_W'($urandom), 3, 1'b0, 20, -1);
    run_scan(DATA_W'($urandom), 2, 1'b0, 3, 3);
    run_scan(8'h07, 4, 1'b1, 0, -1);
    run_scan(8'h03, 1, 1'b0, 1, -1);
    for (int i = 0; i < 6; i++)
      run_scan(DATA_W'($urandom), int'($urandom_range(1, 8)), 1'($urandom),
               int'($urandom_range(0, 6)), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/adc_scan_uart.md
# adc_scan_uart

Parametrised multi-channel ADC scan sequencer with a serial transmitter.
- Steps an external analog multiplexer through `NUM_CH` channels.
- Handshakes one conversion per channel with the external ADC (`soc`/`eoc`).
- Transmits each sample as an asynchronous serial frame gated by `dsr`.
- Successor of the fixed 8-channel, 8-bit, hard-coded-delay b13 block: width, channel count and bit period are generic, and frame timing, flow-control error handling and reset are fully defined.

## Interface
Parameters:
- `NUM_CH`, 8: channels scanned, ≥2. `CH_W = $clog2(NUM_CH)`.
- `DATA_W`, 8: ADC sample width, 4..16.
- `BAUD_DIV`, 104: clocks per serial bit, ≥2.
- `SETTLE_CYC`, 2: mux settle clocks between `mux_en` rise and `soc`, ≥1.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `eoc`  in  1: ADC end of conversion, active-high.
- `data_in`  in  DATA_W: ADC result, valid while `eoc`=1.
- `dsr`  in  1: receiver ready; a frame may start only when 1.
- `soc`  out  1: start of conversion, one-cycle pulse.
- `load_dato`  out  1: one-cycle pulse on sample capture.
- `mux_en`  out  1: analog mux enable.
- `canale`  out  CH_W: selected channel.
- `data_out`  out  1: serial line, idle high.
- `tx_busy`  out  1: frame in progress.
- `error`  out  1: flow-control error flag.

## Operation
- All outputs are registered. Reset values: `soc`=0, `load_dato`=0, `mux_en`=0, `canale`=0, `data_out`=1, `tx_busy`=0, `error`=0. Reset also clears `hold` and the counters and puts the FSM in MUX.
- Reset asserted in any state, including mid-frame, aborts immediately. There is no partial-frame completion.
- Sequencer FSM:
  - MUX: `mux_en`←1, settle counter cleared → SETTLE.
  - SETTLE: stays `SETTLE_CYC` cycles → SOC.
  - SOC: `soc` pulses 1 for exactly one cycle → WAIT.
  - WAIT: holds while `eoc`=0. On `eoc`=1 → LOAD.
  - LOAD: `hold`←`data_in`, `load_dato` pulses, `mux_en`←0 → REQ.
  - REQ: if `dsr`=1, the transmitter starts, `error`←0 → TX. If `dsr`=0, `error`←1 and the FSM stays in REQ; it retries every cycle and never drops the sample.
  - TX: waits for frame end. `canale`←`canale`+1, wrapping `NUM_CH-1`→0 → MUX.
- Transmitter:
  - Frame: start bit (0), `hold` MSB first, optional parity bit, stop bit (1).
  - Each bit is held for exactly `BAUD_DIV` clocks. The bit counter counts 0..`BAUD_DIV-1`.
  - `tx_busy`=1 from the first start-bit cycle through the last stop-bit cycle.
  - `dsr` is sampled only at frame start. Deasserting `dsr` mid-frame does not affect the frame.
- The channel counter is `CH_W` bits wide and compares against `NUM_CH-1`. Non-power-of-two `NUM_CH` never reaches unused codes.

## Timing
- First `reset`-low edge: FSM enters MUX's successor. `mux_en`=1 on the cycle after MUX.
- `soc` rises `SETTLE_CYC`+1 cycles after `mux_en` rises.
- `eoc`=1 in cycle N: `load_dato`=1 and `hold` valid in N+1; `data_out` start bit begins in N+2 when `dsr`=1.
- Frame length: (`DATA_W`+2) × `BAUD_DIV` clocks without parity, (`DATA_W`+3) × `BAUD_DIV` with parity. Defaults give 1040 / 1144.
- `canale` updates on the cycle after the stop bit ends. `mux_en` rises on the following cycle.
- `eoc` already high when SOC is entered is ignored until WAIT. `eoc` pulses outside WAIT are ignored.
- `error` is set in the same cycle `dsr`=0 is seen in REQ. It clears on the cycle the frame starts.

## Configuration
- `ADC_SCAN_UART_PARITY_EN`:
  - Defined: a parity bit equal to XOR of `hold` (even parity) is inserted between the data LSB and the stop bit.
  - Undefined: no parity bit, and the frame is `DATA_W`+2 bits.
  - All other behaviour is identical.

## Test plan
- Reset mid-frame (bit 3 of channel 2): next cycle `data_out`=1, `tx_busy`=0, `canale`=0, and a new scan starts from MUX.
- Defaults, `dsr`=1, `eoc` returned 5 cycles after `soc`, `data_in`=0xA5: line reads 0,1,0,1,0,0,1,0,1,1, each bit 104 clocks; `canale` 0→1.
- Eight consecutive scans with `NUM_CH`=8: `canale` goes 0..7 then 0. With `NUM_CH`=5: 0..4 then 0, never 5.
- `dsr`=0 for 20 cycles at REQ: `error`=1 for exactly those 20 cycles, the frame then starts with the original sample, and `error`=0.
- `ADC_SCAN_UART_PARITY_EN` set with `data_in`=0x07: parity bit 1, frame 1144 clocks. With `data_in`=0x03: parity bit 0.
- `eoc` held high during SETTLE: `soc` still pulses once, and `load_dato` occurs the cycle after WAIT is entered.
